// File: rtl/paint_region.sv
// Rectangle painter for the framebuffer write path: solid, checker and
// stripe fills of a clipped region, emitted as ready/valid pixel writes.
module paint_region #(
    parameter int COOR_WIDTH    = 11,
    parameter int WIDTH         = 1280,
    parameter int HEIGHT        = 300,
    parameter int PALETTE_WIDTH = 2
) (
    input  logic                     clk_33m,
    input  logic                     rst,
    input  logic                     start,
    input  logic [COOR_WIDTH-1:0]    x0,
    input  logic [COOR_WIDTH-1:0]    y0,
    input  logic [COOR_WIDTH-1:0]    w,
    input  logic [COOR_WIDTH-1:0]    h,
    input  logic [1:0]               mode,
    input  logic [PALETTE_WIDTH-1:0] color_a,
    input  logic [PALETTE_WIDTH-1:0] color_b,
    input  logic [2:0]               tile_shift,
    input  logic                     write_ready,
    output logic                     write_en,
    output logic [COOR_WIDTH-1:0]    write_x,
    output logic [COOR_WIDTH-1:0]    write_y,
    output logic [PALETTE_WIDTH-1:0] write_palette,
    output logic                     busy,
    output logic                     finished
);

    localparam int CW = COOR_WIDTH;
    localparam logic [CW:0] X_LIM = (CW+1)'(WIDTH);
    localparam logic [CW:0] Y_LIM = (CW+1)'(HEIGHT);

    typedef enum logic [1:0] {
        IDLE,
        PAINT,
        DONE
    } state_t;

    state_t state, state_next;

    logic [CW-1:0]            x0_q, last_x, last_y;
    logic [CW-1:0]            x, y, rx, ry;
    logic [1:0]               mode_q;
    logic [PALETTE_WIDTH-1:0] ca_q, cb_q;
    logic [2:0]               shift_q;

    // Clip arithmetic is one bit wider so x0+w cannot wrap.
    logic [CW:0] sum_x, sum_y, x_end, y_end, x_end_m1, y_end_m1;
    logic        degenerate, can_start, accept, last_col, last_pix;

    always_comb begin
        sum_x      = {1'b0, x0} + {1'b0, w};
        sum_y      = {1'b0, y0} + {1'b0, h};
        x_end      = (sum_x > X_LIM) ? X_LIM : sum_x;
        y_end      = (sum_y > Y_LIM) ? Y_LIM : sum_y;
        x_end_m1   = x_end - 1'b1;
        y_end_m1   = y_end - 1'b1;
        degenerate = (w == '0) || (h == '0)
                   || ({1'b0, x0} >= X_LIM) || ({1'b0, y0} >= Y_LIM);
    end

    assign can_start = start && (state != PAINT);
    assign accept    = (state == PAINT) && write_ready;
    assign last_col  = (x == last_x);
    assign last_pix  = last_col && (y == last_y);

    always_ff @(posedge clk_33m or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE, DONE: begin
                if (start) state_next = degenerate ? DONE : PAINT;
            end
            PAINT: begin
                if (accept && last_pix) state_next = DONE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_33m or posedge rst) begin
        if (rst) begin
            x0_q    <= '0;
            last_x  <= '0;
            last_y  <= '0;
            x       <= '0;
            y       <= '0;
            rx      <= '0;
            ry      <= '0;
            mode_q  <= '0;
            ca_q    <= '0;
            cb_q    <= '0;
            shift_q <= '0;
        end else if (can_start) begin
            x0_q    <= x0;
            last_x  <= x_end_m1[CW-1:0];
            last_y  <= y_end_m1[CW-1:0];
            x       <= x0;
            y       <= y0;
            rx      <= '0;
            ry      <= '0;
            mode_q  <= mode;
            ca_q    <= color_a;
            cb_q    <= color_b;
            shift_q <= tile_shift;
        end else if (accept) begin
            // Wrap to the next row in the same cycle: no bubble at line end.
            if (last_col) begin
                x  <= x0_q;
                rx <= '0;
                y  <= y + 1'b1;
                ry <= ry + 1'b1;
            end else begin
                x  <= x + 1'b1;
                rx <= rx + 1'b1;
            end
        end
    end

    logic                     sel_b;
    logic [PALETTE_WIDTH-1:0] pal;

    always_comb begin
        sel_b = 1'b0;
        unique case (mode_q)
            2'd0: sel_b = 1'b0;
            2'd1: sel_b = rx[shift_q] ^ ry[shift_q];
            2'd2: sel_b = ry[shift_q];
            2'd3: sel_b = rx[shift_q];
            default: sel_b = 1'b0;
        endcase
        pal = sel_b ? cb_q : ca_q;
    end

    assign write_en      = (state == PAINT);
    assign busy          = (state == PAINT);
    assign finished      = (state == DONE);
    assign write_x       = write_en ? x : '0;
    assign write_y       = write_en ? y : '0;
    assign write_palette = write_en ? pal : '0;

endmodule

// File: tb/tb_paint_region.sv
// Randomised and directed bench for paint_region against a raster-loop
// reference model of the painted region.
module tb_paint_region;

    logic        clk_33m = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [10:0] x0 = '0, y0 = '0, w = '0, h = '0;
    logic [1:0]  mode = '0;
    logic [1:0]  color_a = '0, color_b = '0;
    logic [2:0]  tile_shift = '0;
    logic        write_ready = 1'b0;
    logic        write_en;
    logic [10:0] write_x, write_y;
    logic [1:0]  write_palette;
    logic        busy, finished;

    int errors = 0;
    int checks = 0;

    paint_region dut (
        .clk_33m(clk_33m), .rst(rst), .start(start),
        .x0(x0), .y0(y0), .w(w), .h(h), .mode(mode),
        .color_a(color_a), .color_b(color_b), .tile_shift(tile_shift),
        .write_ready(write_ready), .write_en(write_en),
        .write_x(write_x), .write_y(write_y),
        .write_palette(write_palette), .busy(busy), .finished(finished)
    );

    always #5 clk_33m = ~clk_33m;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // rmode: 0 ready always, 1 random ready, 2 pattern 1,0,0,1,...
    task automatic paint(input int px0, input int py0, input int pw,
                         input int ph, input int pm, input int pa,
                         input int pb, input int ps, input int rmode,
                         input bit inject, input int abort_at);
        int ex[$], ey[$], ep[$];
        int xe, ye, rx, ry, bx, by, sel, n, idx, cycles, budget;
        bit fin;
        ex.delete(); ey.delete(); ep.delete();
        if (pw != 0 && ph != 0 && px0 < 1280 && py0 < 300) begin
            xe = (px0 + pw > 1280) ? 1280 : px0 + pw;
            ye = (py0 + ph > 300) ? 300 : py0 + ph;
            for (int yy = py0; yy < ye; yy++)
                for (int xx = px0; xx < xe; xx++) begin
                    rx = xx - px0;
                    ry = yy - py0;
                    bx = (rx >> ps) & 1;
                    by = (ry >> ps) & 1;
                    case (pm)
                        1: sel = bx ^ by;
                        2: sel = by;
                        3: sel = bx;
                        default: sel = 0;
                    endcase
                    ex.push_back(xx);
                    ey.push_back(yy);
                    ep.push_back(sel ? pb : pa);
                end
        end
        n = ex.size();
        budget = n * 8 + 16;
        @(negedge clk_33m);
        x0 = 11'(px0); y0 = 11'(py0); w = 11'(pw); h = 11'(ph);
        mode = 2'(pm); color_a = 2'(pa); color_b = 2'(pb);
        tile_shift = 3'(ps);
        start = 1'b1;
        idx = 0; cycles = 0; fin = 1'b0;
        while (!fin && cycles < budget) begin
            @(negedge clk_33m);
            cycles++;
            start = 1'b0;
            if (abort_at == cycles) begin
                #2 rst = 1'b1;
                #1;
                chk("abort_en", 32'(write_en), 0);
                chk("abort_busy", 32'(busy), 0);
                chk("abort_fin", 32'(finished), 0);
                rst = 1'b0;
                return;
            end
            if (write_en) begin
                chk("busy_in_paint", 32'(busy), 1);
                chk("fin_in_paint", 32'(finished), 0);
                chk("no_extra_write", 32'(idx < n), 1);
                if (idx < n) begin
                    chk("wx", 32'(write_x), 32'(ex[idx]));
                    chk("wy", 32'(write_y), 32'(ey[idx]));
                    chk("wpal", 32'(write_palette), 32'(ep[idx]));
                end
            end else begin
                chk("idle_x_zero", 32'(write_x), 0);
                chk("idle_y_zero", 32'(write_y), 0);
                chk("idle_pal_zero", 32'(write_palette), 0);
                chk("en_low_means_fin", 32'(finished), 1);
                fin = 1'b1;
            end
            if (inject && cycles == 3) begin
                start = 1'b1;
                x0 = 11'($urandom_range(0, 1279));
                y0 = 11'($urandom_range(0, 299));
                w = 11'($urandom_range(1, 9));
                h = 11'($urandom_range(1, 9));
                mode = 2'($urandom);
                color_a = 2'($urandom);
                color_b = 2'($urandom);
            end
            case (rmode)
                0: write_ready = 1'b1;
                1: write_ready = ($urandom_range(0, 3) != 0);
                default: write_ready = (cycles % 4 == 1) || (cycles % 4 == 0);
            endcase
            if (write_en && write_ready) idx++;
        end
        chk("finished_seen", 32'(fin), 1);
        chk("write_count", 32'(idx), 32'(n));
        chk("busy_after", 32'(busy), 0);
        if (rmode == 0) chk("done_latency", 32'(cycles), 32'(n + 1));
    endtask

    initial begin
        #2;
        chk("rst_en", 32'(write_en), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_fin", 32'(finished), 0);
        chk("rst_x", 32'(write_x), 0);
        chk("rst_pal", 32'(write_palette), 0);
        @(negedge clk_33m);
        rst = 1'b0;

        paint(10, 20, 4, 2, 1, 1, 2, 0, 0, 1'b0, 0);
        paint(1278, 298, 5, 5, 0, 3, 0, 0, 0, 1'b0, 0);
        paint(100, 5, 3, 1, 2, 1, 3, 1, 2, 1'b0, 0);
        paint(50, 50, 0, 4, 0, 1, 0, 0, 0, 1'b0, 0);
        paint(1280, 50, 4, 4, 0, 1, 0, 0, 0, 1'b0, 0);
        paint(7, 299, 6, 9, 3, 2, 1, 1, 1, 1'b0, 0);
        paint(0, 260, 1280, 2047, 1, 1, 2, 3, 0, 1'b0, 0);

        paint(10, 20, 4, 3, 1, 1, 2, 0, 0, 1'b0, 5);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_33m);
            chk("post_abort_en", 32'(write_en), 0);
            chk("post_abort_fin", 32'(finished), 0);
        end
        paint(10, 20, 4, 3, 1, 1, 2, 0, 0, 1'b0, 0);
        paint(30, 40, 5, 3, 3, 0, 3, 1, 1, 1'b1, 0);

        for (int i = 0; i < 40; i++)
            paint($urandom_range(0, 1290), $urandom_range(0, 305),
                  $urandom_range(0, 18), $urandom_range(0, 12),
                  $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 2), 1'b0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
